// File: rtl/round_encrypt_if.sv
// Bus bundle for round_encrypt: round inputs, start level, registered result and debug state.
interface round_encrypt_if #(
  parameter int BLOCK_SIZE = 16,
  parameter int KEY_SIZE   = 32
);
  logic [BLOCK_SIZE-1:0] subkey;
  logic [KEY_SIZE-1:0]   plaintext;
  logic                  signal_start;
  logic [KEY_SIZE-1:0]   ciphertext;
  logic                  finished;
  logic [3:0]            state_response;

  modport master (
    output subkey, plaintext, signal_start,
    input  ciphertext, finished, state_response
  );

  modport slave (
    input  subkey, plaintext, signal_start,
    output ciphertext, finished, state_response
  );
endinterface

// File: rtl/round_encrypt.sv
// One SPECK encryption round, one step per state; define ROUND_ENCRYPT_FAST_PATH_EN to
// collapse rotate/add/xor steps into the ROTATE state.
module round_encrypt #(
  parameter int BLOCK_SIZE     = 16,
  parameter int KEY_SIZE       = 32,
  parameter int SHIFT_WIDTH_P0 = 7,
  parameter int SHIFT_WIDTH_P1 = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  round_encrypt_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ROTATE  = 3'd2,
    ADD     = 3'd3,
    XOR_KEY = 3'd4,
    XOR_Y   = 3'd5,
    RESULT  = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t                state_reg, state_next;
  logic [BLOCK_SIZE-1:0] x_reg, y_reg, k_reg;
  logic [KEY_SIZE-1:0]   ciphertext_reg;
  logic                  finished_reg;

  logic [BLOCK_SIZE-1:0] x_rot, y_rot, y_unrot;
  logic [BLOCK_SIZE-1:0] x_key_fast, y_fast;

  assign x_rot   = (x_reg >> SHIFT_WIDTH_P0) | (x_reg << (BLOCK_SIZE - SHIFT_WIDTH_P0));
  assign y_rot   = (y_reg << SHIFT_WIDTH_P1) | (y_reg >> (BLOCK_SIZE - SHIFT_WIDTH_P1));
  // The SPECK add uses y before its rotation; y_reg is already rotated by the time ADD runs.
  assign y_unrot = (y_reg >> SHIFT_WIDTH_P1) | (y_reg << (BLOCK_SIZE - SHIFT_WIDTH_P1));

  assign x_key_fast = (x_rot + y_reg) ^ k_reg;
  assign y_fast     = y_rot ^ x_key_fast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.signal_start) state_next = LOAD;
      LOAD:    state_next = ROTATE;
`ifdef ROUND_ENCRYPT_FAST_PATH_EN
      ROTATE:  state_next = RESULT;
`else
      ROTATE:  state_next = ADD;
`endif
      ADD:     state_next = XOR_KEY;
      XOR_KEY: state_next = XOR_Y;
      XOR_Y:   state_next = RESULT;
      RESULT:  state_next = DONE;
      DONE:    if (!bus.signal_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg          <= '0;
      y_reg          <= '0;
      k_reg          <= '0;
      ciphertext_reg <= '0;
      finished_reg   <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          x_reg <= bus.plaintext[BLOCK_SIZE-1:0];
          y_reg <= bus.plaintext[KEY_SIZE-1:BLOCK_SIZE];
          k_reg <= bus.subkey;
        end
        ROTATE: begin
`ifdef ROUND_ENCRYPT_FAST_PATH_EN
          x_reg <= x_key_fast;
          y_reg <= y_fast;
`else
          x_reg <= x_rot;
          y_reg <= y_rot;
`endif
        end
        ADD:     x_reg <= x_reg + y_unrot;
        XOR_KEY: x_reg <= x_reg ^ k_reg;
        XOR_Y:   y_reg <= y_reg ^ x_reg;
        RESULT: begin
          ciphertext_reg <= {y_reg, x_reg};
          finished_reg   <= 1'b1;
        end
        DONE:    if (!bus.signal_start) finished_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.ciphertext     = ciphertext_reg;
  assign bus.finished       = finished_reg;
  assign bus.state_response = {1'b0, state_reg};

endmodule
